// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter/sequencer sharing one UART tx serializer among NUM_REQ byte producers.
// Define UART_ARB_PRIO0_EN to give requester 0 strict priority over a round-robin of the rest.
module uart_tx_arbiter #(
    parameter int unsigned NUM_REQ        = 4,
    parameter int unsigned DATA_BITS      = 8,
    parameter int unsigned TIMEOUT_CYCLES = 65535
) (
    input  logic                           clk,
    input  logic                           arst_n,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [NUM_REQ*DATA_BITS-1:0]   req_data,
    output logic [NUM_REQ-1:0]             req_ready,
    output logic                           tx_start,
    output logic [DATA_BITS-1:0]           tx_din,
    input  logic                           tx_done,
    input  logic                           tx_idle,
    output logic [$clog2(NUM_REQ)-1:0]     grant_id,
    output logic                           busy,
    output logic                           timeout_err,
    input  logic                           err_clr
);

    localparam int unsigned ID_W = $clog2(NUM_REQ);
    localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_LAUNCH    = 2'd1,
        S_WAIT_DONE = 2'd2
    } state_t;

    state_t                state;
    logic [ID_W-1:0]       ptr;
    logic [WD_W-1:0]       wd_cnt;
    logic [ID_W-1:0]       winner_c;
    logic                  found_c;
    logic                  grant_c;
    logic [DATA_BITS-1:0]  data_c;
    int unsigned           idx;

    // Winner search: first valid index after ptr, wrapping.
    always_comb begin
        winner_c = '0;
        found_c  = 1'b0;
        idx      = 0;
`ifdef UART_ARB_PRIO0_EN
        if (req_valid[0]) begin
            found_c = 1'b1;
        end else begin
            for (int unsigned k = 1; k < NUM_REQ; k++) begin
                idx = 1 + ((32'(ptr) + NUM_REQ - 2 + k) % (NUM_REQ - 1));
                if (!found_c && req_valid[idx]) begin
                    found_c  = 1'b1;
                    winner_c = ID_W'(idx);
                end
            end
        end
`else
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            idx = (32'(ptr) + k) % NUM_REQ;
            if (!found_c && req_valid[idx]) begin
                found_c  = 1'b1;
                winner_c = ID_W'(idx);
            end
        end
`endif
    end

    assign data_c    = req_data[32'(winner_c)*DATA_BITS +: DATA_BITS];
    assign grant_c   = arst_n && (state == S_IDLE) && tx_idle && found_c;
    assign req_ready = grant_c ? (NUM_REQ'(1) << winner_c) : '0;

    // Sequencer: accept, launch, then wait for stop-bit completion or watchdog expiry.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state       <= S_IDLE;
            ptr         <= ID_W'(NUM_REQ - 1);
            wd_cnt      <= '0;
            tx_start    <= 1'b0;
            tx_din      <= '0;
            grant_id    <= '0;
            busy        <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            tx_start <= 1'b0;
            if (err_clr) begin
                timeout_err <= 1'b0;
            end
            case (state)
                S_IDLE: begin
                    if (grant_c) begin
                        tx_din   <= data_c;
                        grant_id <= winner_c;
                        tx_start <= 1'b1;
                        busy     <= 1'b1;
                        state    <= S_LAUNCH;
                    end
                end
                S_LAUNCH: begin
                    wd_cnt <= '0;
                    state  <= S_WAIT_DONE;
                end
                S_WAIT_DONE: begin
                    if (tx_done || (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1))) begin
                        if (!tx_done) begin
                            timeout_err <= 1'b1;
                        end
`ifdef UART_ARB_PRIO0_EN
                        if (grant_id != '0) begin
                            ptr <= grant_id;
                        end
`else
                        ptr <= grant_id;
`endif
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end else if (wd_cnt != WD_W'(TIMEOUT_CYCLES)) begin
                        wd_cnt <= wd_cnt + WD_W'(1);
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: directed scenarios plus randomized traffic
// checked against a round-robin reference model.
`timescale 1ns/1ps
module tb_uart_tx_arbiter;

    localparam int unsigned NUM_REQ        = 4;
    localparam int unsigned DATA_BITS      = 8;
    localparam int unsigned TIMEOUT_CYCLES = 20;
    localparam int unsigned ID_W           = $clog2(NUM_REQ);

    logic                         clk       = 1'b0;
    logic                         arst_n    = 1'b1;
    logic [NUM_REQ-1:0]           req_valid = '0;
    logic [NUM_REQ*DATA_BITS-1:0] req_data  = '0;
    logic [NUM_REQ-1:0]           req_ready;
    logic                         tx_start;
    logic [DATA_BITS-1:0]         tx_din;
    logic                         tx_done   = 1'b0;
    logic                         tx_idle   = 1'b1;
    logic [ID_W-1:0]              grant_id;
    logic                         busy;
    logic                         timeout_err;
    logic                         err_clr   = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;
    int model_ptr = NUM_REQ - 1;
    logic [DATA_BITS-1:0] bytes [NUM_REQ];

    uart_tx_arbiter #(
        .NUM_REQ       (NUM_REQ),
        .DATA_BITS     (DATA_BITS),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) dut (
        .clk        (clk),
        .arst_n     (arst_n),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .tx_start   (tx_start),
        .tx_din     (tx_din),
        .tx_done    (tx_done),
        .tx_idle    (tx_idle),
        .grant_id   (grant_id),
        .busy       (busy),
        .timeout_err(timeout_err),
        .err_clr    (err_clr)
    );

    always #5 clk = ~clk;

    // Reference: next requester after the last served one, in circular order.
    function automatic int pick(input logic [NUM_REQ-1:0] v, input int p);
        int n = int'(NUM_REQ);
`ifdef UART_ARB_PRIO0_EN
        if (v[0]) return 0;
        for (int k = 1; k < n; k++) begin
            int i = ((p - 1 + k) % (n - 1)) + 1;
            if (v[i]) return i;
        end
`else
        for (int k = 1; k <= n; k++) begin
            int i = (p + k) % n;
            if (v[i]) return i;
        end
`endif
        return -1;
    endfunction

    function automatic int next_ptr(input int w, input int p);
`ifdef UART_ARB_PRIO0_EN
        if (w == 0) return p;
`endif
        return w;
    endfunction

    function automatic logic [NUM_REQ-1:0] onehot(input int i);
        logic [NUM_REQ-1:0] v = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_data();
        for (int i = 0; i < int'(NUM_REQ); i++) req_data[i*DATA_BITS +: DATA_BITS] = bytes[i];
    endtask

    task automatic apply_reset();
        req_valid = '0;
        tx_done   = 1'b0;
        tx_idle   = 1'b1;
        err_clr   = 1'b0;
        arst_n    = 1'b0;
        repeat (2) @(posedge clk);
        #1 arst_n = 1'b1;
        model_ptr = NUM_REQ - 1;
        tick();
    endtask

    // Serializer stand-in: completes the frame after len extra WAIT_DONE cycles.
    task automatic finish_frame(input int len);
        repeat (len) tick();
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
    endtask

    task automatic test_reset();
        #2 arst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if ({req_ready, tx_start, tx_din, grant_id, busy, timeout_err} !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs got %h want 0",
                     {req_ready, tx_start, tx_din, grant_id, busy, timeout_err});
        end
        arst_n = 1'b1;
        model_ptr = NUM_REQ - 1;
        tick();
    endtask

    task automatic test_basic();
        bytes[0] = 8'hA5;
        load_data();
        req_valid = 4'b0001;
        #1;
        n_cmp++;
        if (req_ready !== 4'b0001) begin
            n_bad++; $display("FAIL basic_ready got %b want 0001", req_ready);
        end
        tick();
        req_valid = '0;
        n_cmp++;
        if ({tx_start, tx_din, grant_id, busy} !== {1'b1, 8'hA5, 2'd0, 1'b1}) begin
            n_bad++; $display("FAIL basic_launch got start=%b din=%h id=%0d busy=%b want 1 a5 0 1",
                              tx_start, tx_din, grant_id, busy);
        end
        n_cmp++;
        if (req_ready !== '0) begin
            n_bad++; $display("FAIL basic_ready_pulse got %b want 0000", req_ready);
        end
        tick();
        n_cmp++;
        if ({tx_start, tx_din, busy} !== {1'b0, 8'hA5, 1'b1}) begin
            n_bad++; $display("FAIL basic_wait got start=%b din=%h busy=%b want 0 a5 1", tx_start, tx_din, busy);
        end
        repeat (3) tick();
        tx_done = 1'b1;
        #1;
        n_cmp++;
        if (busy !== 1'b1) begin
            n_bad++; $display("FAIL basic_busy_at_done got %b want 1", busy);
        end
        tick();
        tx_done = 1'b0;
        n_cmp++;
        if ({busy, grant_id} !== {1'b0, 2'd0}) begin
            n_bad++; $display("FAIL basic_release got busy=%b id=%0d want 0 0", busy, grant_id);
        end
        model_ptr = 0;
    endtask

    task automatic test_round_robin();
        int order [5] = '{0, 1, 2, 3, 0};
        apply_reset();
        bytes[0] = 8'h10; bytes[1] = 8'h21; bytes[2] = 8'h32; bytes[3] = 8'h43;
        load_data();
        req_valid = 4'b1111;
        for (int it = 0; it < 5; it++) begin
            int e = order[it];
            #1;
            n_cmp++;
            if (req_ready !== onehot(e)) begin
                n_bad++; $display("FAIL rr_ready[%0d] got %b want %b", it, req_ready, onehot(e));
            end
            tick();
            n_cmp++;
            if ({tx_start, tx_din, grant_id} !== {1'b1, bytes[e], ID_W'(e)}) begin
                n_bad++; $display("FAIL rr_launch[%0d] got start=%b din=%h id=%0d want 1 %h %0d",
                                  it, tx_start, tx_din, grant_id, bytes[e], e);
            end
            tick();
            n_cmp++;
            if (tx_start !== 1'b0) begin
                n_bad++; $display("FAIL rr_single_start[%0d] got %b want 0", it, tx_start);
            end
            if (it == 4) req_valid = '0;
            finish_frame(it + 1);
            model_ptr = e;
        end
        req_valid = '0;
    endtask

    task automatic test_idle_block();
        tx_idle = 1'b0;
        req_valid = 4'b0010;
        for (int c = 0; c < 6; c++) begin
            if (c == 3) req_valid = 4'b0100;
            if (c == 4) tx_done = 1'b1;
            if (c == 5) tx_done = 1'b0;
            #1;
            n_cmp++;
            if ({req_ready, tx_start, busy} !== '0) begin
                n_bad++; $display("FAIL idle_block[%0d] got ready=%b start=%b busy=%b want 0", c, req_ready, tx_start, busy);
            end
            tick();
        end
        bytes[2] = 8'(($urandom));
        load_data();
        tx_idle = 1'b1;
        #1;
        n_cmp++;
        if (req_ready !== 4'b0100) begin
            n_bad++; $display("FAIL idle_release_ready got %b want 0100", req_ready);
        end
        tick();
        req_valid = '0;
        n_cmp++;
        if ({tx_start, grant_id, tx_din} !== {1'b1, 2'd2, bytes[2]}) begin
            n_bad++; $display("FAIL idle_release_launch got start=%b id=%0d din=%h want 1 2 %h",
                              tx_start, grant_id, tx_din, bytes[2]);
        end
        tick();
        finish_frame(2);
        model_ptr = 2;
    endtask

    task automatic test_timeout();
        int e;
        int cnt;
        for (int i = 0; i < int'(NUM_REQ); i++) bytes[i] = 8'($urandom);
        load_data();
        for (int f = 0; f < 3; f++) begin
            req_valid = 4'b1011;
            e = pick(req_valid, model_ptr);
            #1;
            n_cmp++;
            if (req_ready !== onehot(e)) begin
                n_bad++; $display("FAIL to_ready[%0d] got %b want %b", f, req_ready, onehot(e));
            end
            tick();
            req_valid = '0;
            n_cmp++;
            if ({tx_start, tx_din, grant_id} !== {1'b1, bytes[e], ID_W'(e)}) begin
                n_bad++; $display("FAIL to_launch[%0d] got start=%b din=%h id=%0d want 1 %h %0d",
                                  f, tx_start, tx_din, grant_id, bytes[e], e);
            end
            if (f == 1) begin
                // Middle frame completes normally and clears the flag on the way.
                err_clr = 1'b1;
                tick();
                err_clr = 1'b0;
                n_cmp++;
                if (timeout_err !== 1'b0) begin
                    n_bad++; $display("FAIL to_err_clr got %b want 0", timeout_err);
                end
                finish_frame(2);
            end else begin
                if (f == 2) err_clr = 1'b1;
                cnt = 0;
                do begin
                    tick();
                    cnt++;
                    if (cnt == int'(TIMEOUT_CYCLES)) begin
                        n_cmp++;
                        if ({busy, timeout_err} !== {1'b1, 1'b0}) begin
                            n_bad++; $display("FAIL to_early[%0d] got busy=%b err=%b want 1 0", f, busy, timeout_err);
                        end
                    end
                end while (busy === 1'b1 && cnt < 100);
                n_cmp++;
                if (cnt != int'(TIMEOUT_CYCLES) + 1 || timeout_err !== 1'b1) begin
                    n_bad++; $display("FAIL to_expire[%0d] got cycles=%0d err=%b want %0d 1",
                                      f, cnt, timeout_err, TIMEOUT_CYCLES + 1);
                end
                if (f == 2) begin
                    tick();
                    err_clr = 1'b0;
                    n_cmp++;
                    if (timeout_err !== 1'b0) begin
                        n_bad++; $display("FAIL to_held_clr got %b want 0", timeout_err);
                    end
                end
            end
            model_ptr = next_ptr(e, model_ptr);
        end
    endtask

    task automatic test_reset_mid();
        int e;
        req_valid = 4'b1111;
        e = pick(req_valid, model_ptr);
        tick();
        tick();
        tick();
        #2 arst_n = 1'b0;
        #1;
        n_cmp++;
        if ({req_ready, tx_start, tx_din, grant_id, busy, timeout_err} !== '0) begin
            n_bad++; $display("FAIL reset_mid got %h want 0 (owner was %0d)",
                              {req_ready, tx_start, tx_din, grant_id, busy, timeout_err}, e);
        end
        @(posedge clk);
        #1 arst_n = 1'b1;
        model_ptr = NUM_REQ - 1;
        #1;
        n_cmp++;
        if (req_ready !== 4'b0001) begin
            n_bad++; $display("FAIL reset_mid_first got %b want 0001", req_ready);
        end
        tick();
        n_cmp++;
        if ({tx_start, grant_id} !== {1'b1, 2'd0}) begin
            n_bad++; $display("FAIL reset_mid_launch got start=%b id=%0d want 1 0", tx_start, grant_id);
        end
        req_valid = '0;
        tick();
        finish_frame(1);
        model_ptr = next_ptr(0, model_ptr);
    endtask

`ifdef UART_ARB_PRIO0_EN
    task automatic test_prio();
        int order [6] = '{0, 0, 0, 1, 2, 3};
        apply_reset();
        for (int i = 0; i < int'(NUM_REQ); i++) bytes[i] = 8'($urandom);
        load_data();
        req_valid = 4'b1111;
        for (int it = 0; it < 6; it++) begin
            if (it == 3) req_valid = 4'b1110;
            #1;
            n_cmp++;
            if (req_ready !== onehot(order[it])) begin
                n_bad++; $display("FAIL prio_ready[%0d] got %b want %b", it, req_ready, onehot(order[it]));
            end
            tick();
            tick();
            if (it == 5) req_valid = '0;
            finish_frame(1);
            model_ptr = next_ptr(order[it], model_ptr);
        end
    endtask
`endif

    task automatic test_random();
        int e;
        int w;
        for (int it = 0; it < 40; it++) begin
            if (req_valid == '0) begin
                req_valid = NUM_REQ'($urandom_range(1, (1 << NUM_REQ) - 1));
                for (int i = 0; i < int'(NUM_REQ); i++) bytes[i] = 8'($urandom);
                load_data();
            end
            w = $urandom_range(0, 2);
            for (int c = 0; c < w; c++) begin
                tx_idle = 1'b0;
                tx_done = $urandom_range(0, 1) == 1;
                #1;
                n_cmp++;
                if ({req_ready, busy} !== '0) begin
                    n_bad++; $display("FAIL rnd_blocked[%0d] got ready=%b busy=%b want 0", it, req_ready, busy);
                end
                tick();
            end
            tx_done = 1'b0;
            tx_idle = 1'b1;
            e = pick(req_valid, model_ptr);
            #1;
            n_cmp++;
            if (req_ready !== onehot(e)) begin
                n_bad++; $display("FAIL rnd_ready[%0d] got %b want %b valid=%b", it, req_ready, onehot(e), req_valid);
            end
            tick();
            n_cmp++;
            if ({tx_start, tx_din, grant_id} !== {1'b1, bytes[e], ID_W'(e)}) begin
                n_bad++; $display("FAIL rnd_launch[%0d] got start=%b din=%h id=%0d want 1 %h %0d",
                                  it, tx_start, tx_din, grant_id, bytes[e], e);
            end
            req_valid[e] = $urandom_range(0, 1) == 1;
            bytes[e] = 8'($urandom);
            load_data();
            if ($urandom_range(0, 3) == 0) begin
                tx_done = 1'b1;
                tick();
                tx_done = 1'b0;
                n_cmp++;
                if ({busy, tx_start} !== {1'b1, 1'b0}) begin
                    n_bad++; $display("FAIL rnd_done_in_launch[%0d] got busy=%b start=%b want 1 0", it, busy, tx_start);
                end
            end else begin
                tick();
            end
            finish_frame($urandom_range(0, 6));
            model_ptr = next_ptr(e, model_ptr);
        end
        req_valid = '0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_time_limit got running want finished");
        $fatal(1, "time limit");
    end

    initial begin
        for (int i = 0; i < int'(NUM_REQ); i++) bytes[i] = '0;
        test_reset();
        test_basic();
        test_round_robin();
        test_idle_block();
        test_timeout();
        test_reset_mid();
`ifdef UART_ARB_PRIO0_EN
        test_prio();
`endif
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
